fc_argmax_stage: RTL and testbench

//  Downstream consumer of a fully-connected layer's output stream (M signed
//  T-bit results, one per valid/ready beat). Collects one M-element frame,

---
 rtl/fc_argmax_stage.sv | 96 +++++++++
 tb/tb_fc_argmax_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_stage.sv
// Argmax over one M-element frame of signed fc outputs; emits {index, max} as one result beat.
// Latency: output_valid rises the cycle after the M-th element is accepted; M+1 cycles/frame minimum.
// Backpressure: input_ready is low while a result is pending; the result holds until output_ready.
module fc_argmax_stage #(
   parameter  int M    = 8,
   parameter  int T    = 16,
   localparam int IDXW = (M > 1) ? $clog2(M) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            input_valid,
   output logic            input_ready,
   input  logic [T-1:0]    input_data,
   output logic            output_valid,
   input  logic            output_ready,
   output logic [IDXW-1:0] output_index,
   output logic [T-1:0]    output_max
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDXW-1:0]        elem_cnt;
   logic [IDXW-1:0]        best_idx;
   logic signed [T-1:0]    best_val;
   logic                   accept;
   logic                   last_elem;

   assign accept    = input_valid & input_ready;
   assign last_elem = (elem_cnt == LAST_IDX);

   // State register: one frame collected, then one result slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; both depend only on registered state (and reset).
   always_comb begin
      state_nxt    = state;
      input_ready  = 1'b0;
      output_valid = 1'b0;
      case (state)
         COLLECT: begin
            input_ready = ~reset;
            if (accept && last_elem) begin
               state_nxt = RESULT;
            end
         end
         RESULT: begin
            output_valid = 1'b1;
            if (output_ready) begin
               state_nxt = COLLECT;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

   // Running maximum: first element loads unconditionally, later ones replace only if strictly greater.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         elem_cnt <= '0;
         best_idx <= '0;
         best_val <= '0;
      end else if (accept) begin
         if (elem_cnt == '0) begin
            best_val <= $signed(input_data);
            best_idx <= '0;
         end else if ($signed(input_data) > best_val) begin
            best_val <= $signed(input_data);
            best_idx <= elem_cnt;
         end
         if (last_elem) begin
            elem_cnt <= '0;
         end else begin
            elem_cnt <= elem_cnt + 1'b1;
         end
      end
   end

   assign output_index = best_idx;
   assign output_max   = best_val;

endmodule

// File: tb/tb_fc_argmax_stage.sv
// Self-checking bench for fc_argmax_stage: directed frames plus random frames against an argmax model.
// Latency: checks output_valid one cycle after each frame's last accept.
// Backpressure: random valid gaps and output_ready stalls; upstream holds unaccepted beats.
module tb_fc_argmax_stage;

   localparam int M    = 8;
   localparam int T    = 16;
   localparam int IDXW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            input_valid;
   logic            input_ready;
   logic [T-1:0]    input_data;
   logic            output_valid;
   logic            output_ready;
   logic [IDXW-1:0] output_index;
   logic [T-1:0]    output_max;

   fc_argmax_stage #(.M(M), .T(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_index (output_index),
      .output_max   (output_max)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDXW-1:0] idx;
      logic [T-1:0]    val;
   } res_t;

   int                  checks = 0;
   int                  errors = 0;
   logic [T-1:0]        in_q[$];
   res_t                exp_q[$];
   logic signed [T-1:0] frame[M];
   int                  acc_cnt  = 0;
   bit                  last_acc = 0;
   bit                  lat_pend = 0;
   bit                  drop_pend = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference: find the largest value, then the first position holding it.
   task automatic push_frame();
      logic signed [T-1:0] mx;
      int                  first;
      mx = frame[0];
      foreach (frame[i]) if (frame[i] > mx) mx = frame[i];
      first = -1;
      foreach (frame[i]) if (first < 0 && frame[i] == mx) first = i;
      foreach (frame[i]) in_q.push_back(frame[i]);
      exp_q.push_back('{idx: IDXW'(first), val: mx});
   endtask

   // Checks that fall due one cycle after an event seen at the previous negedge.
   task automatic post_checks();
      if (lat_pend) begin
         check("latency_valid", output_valid, 1);
         lat_pend = 0;
      end
      if (drop_pend) begin
         check("valid_drop", output_valid, 0);
         drop_pend = 0;
      end
   endtask

   // Drive inputs at a negedge and book the handshakes the next posedge will perform.
   task automatic step_drive(input int vld_pct, input int rdy_pct, input bit hold_out);
      if (!(input_valid && !last_acc)) begin
         input_valid = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
      end
      input_data   = input_valid ? in_q[0] : T'($urandom);
      output_ready = hold_out ? 1'b0 : ($urandom_range(99) < rdy_pct);
      check("ready_valid_exclusive", {31'd0, output_valid & input_ready}, 0);
      last_acc = input_valid && input_ready;
      if (last_acc) begin
         void'(in_q.pop_front());
         acc_cnt++;
         if (acc_cnt % M == 0) lat_pend = 1;
      end
      if (output_valid && output_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", exp_q.size(), 1);
         end else begin
            check("index", output_index, exp_q[0].idx);
            check("max", output_max, exp_q[0].val);
            void'(exp_q.pop_front());
         end
         drop_pend = 1;
      end
   endtask

   task automatic run(input int vld_pct, input int rdy_pct, input bit stop_on_valid);
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 3000) begin
         @(negedge clk);
         budget++;
         post_checks();
         if (stop_on_valid && output_valid) break;
         step_drive(vld_pct, rdy_pct, stop_on_valid);
      end
      if (budget >= 3000) check("timeout_results_left", exp_q.size(), 0);
   endtask

   task automatic clear_model();
      in_q.delete();
      exp_q.delete();
      acc_cnt   = 0;
      last_acc  = 0;
      lat_pend  = 0;
      drop_pend = 0;
   endtask

   initial begin
      reset        = 1'b1;
      input_valid  = 1'b0;
      input_data   = '0;
      output_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_input_ready", input_ready, 0);
      check("rst_output_valid", output_valid, 0);
      check("rst_output_index", output_index, 0);
      check("rst_output_max", output_max, 0);
      reset = 1'b0;
      #1;
      check("post_rst_input_ready", input_ready, 1);

      // T1: basic frame, downstream always ready
      frame = '{46, 121, 85, -4, -76, -111, -16, -80};
      push_frame();
      run(100, 100, 0);

      // T2: all negative, tie on -3 keeps index 1
      frame = '{-5, -3, -300, -3, -9, -7, -32768, -4};
      push_frame();
      run(100, 100, 0);

      // T3: maximum in last slot, random valid gaps
      frame = '{0, 0, 0, 0, 0, 0, 0, 32767};
      push_frame();
      run(40, 100, 0);

      // T4: result held under output_ready=0 while the next frame is offered
      foreach (frame[i]) frame[i] = T'($urandom);
      push_frame();
      foreach (frame[i]) frame[i] = T'($urandom);
      push_frame();
      run(100, 0, 1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(negedge clk);
            post_checks();
         end
         input_valid  = 1'b1;
         input_data   = in_q[0];
         output_ready = 1'b0;
         check("hold_valid", output_valid, 1);
         check("hold_in_ready", input_ready, 0);
         check("hold_index", output_index, exp_q[0].idx);
         check("hold_max", output_max, exp_q[0].val);
         last_acc = input_valid && input_ready;
      end
      @(negedge clk);
      post_checks();
      output_ready = 1'b1;
      check("release_valid", output_valid, 1);
      check("release_index", output_index, exp_q[0].idx);
      check("release_max", output_max, exp_q[0].val);
      void'(exp_q.pop_front());
      drop_pend = 1;
      last_acc  = input_valid && input_ready;
      @(negedge clk);
      post_checks();
      check("release_in_ready", input_ready, 1);
      step_drive(100, 100, 0);
      run(100, 100, 0);

      // T5a: reset while a result is pending drops output_valid asynchronously
      foreach (frame[i]) frame[i] = T'($urandom);
      push_frame();
      run(100, 0, 1);
      check("pre_reset_valid", output_valid, 1);
      input_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("reset_result_valid", output_valid, 0);
      check("reset_result_in_ready", input_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      clear_model();

      // T5b: reset after three accepted elements, then a clean frame
      frame = '{9, 1, 2, 3, 4, 5, 6, 7};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         input_valid = 1'b1;
         input_data  = frame[k];
         check("partial_in_ready", input_ready, 1);
      end
      @(negedge clk);
      input_valid = 1'b0;
      check("partial_max_loaded", output_max, 9);
      #2 reset = 1'b1;
      #1;
      check("mid_reset_max", output_max, 0);
      check("mid_reset_index", output_index, 0);
      check("mid_reset_valid", output_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      frame = '{1, 2, 3, 4, 5, 6, 7, 8};
      push_frame();
      run(100, 100, 0);

      // T6: ten random frames with stalls on both sides; small ranges force ties
      for (int f = 0; f < 10; f++) begin
         foreach (frame[i]) begin
            if (f % 2 == 0) frame[i] = T'($urandom);
            else            frame[i] = T'($signed($urandom_range(6)) - 3);
         end
         push_frame();
      end
      run(70, 60, 0);
      @(negedge clk);
      post_checks();
      check("frames_left", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
